branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-stage branch prediction source for the pipelined LC-3b core. It holds a direct-mapped branch target buffer (BTB) and a gshare-style pattern history table (PHT) of 2-bit saturating counters. For the current fetch PC it drives btb_hit, btb_uc, btb_target and pht_out to the hazard unit and PC mux. It is trained by branch resolution from the MEM stage.

Parameters:
IDX_BITS, 4, log2 of BTB and PHT entry count (16 entries each); also the global history register (GHR) width
TAG_BITS, 15-IDX_BITS, BTB tag width (pc[15:IDX_BITS+1])

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_pc  in  16  fetch-stage PC (lc3b_word)
btb_hit  out  1  valid BTB entry with matching tag for if_pc
btb_uc  out  1  hit entry is an unconditional branch (JMP/JSR/BR nzp)
btb_target  out  16  predicted target from the indexed entry
pht_out  out  1  MSB of the indexed PHT counter (1 = predict taken)
pht_idx  out  IDX_BITS  PHT index used for this fetch; carried down the pipeline
upd_valid  in  1  single-cycle pulse: resolved branch in MEM, at most once per instruction
upd_pc  in  16  PC of the resolved branch
upd_target  in  16  resolved target
upd_taken  in  1  resolved direction (BEN, or 1 for unconditional)
upd_uncond  in  1  resolved branch is unconditional
upd_pht_idx  in  IDX_BITS  pht_idx captured at that branch's fetch

Behaviour:
- Lookup is purely combinational from if_pc and state; no added fetch latency.
- Indexing:
  - bidx = if_pc[IDX_BITS:1]
  - pht_idx = bidx XOR ghr
  - tag = if_pc[15:IDX_BITS+1]
- Output derivation:
  - btb_hit = valid[bidx] & (tag matches)
  - btb_uc = btb_hit & uc[bidx]
  - btb_target = target[bidx], regardless of hit
  - pht_out = cnt[pht_idx][1], regardless of hit
- Reset (synchronous, wins over upd_valid in the same cycle):
  - all valid, uc, tag and target bits cleared to 0
  - all counters set to 2'b01 (weakly not-taken)
  - ghr = 0
  - after reset: btb_hit=0, btb_uc=0, btb_target=0x0000, pht_out=0
- Update, on the clock edge with upd_valid=1 and reset=0:
  - BTB write at ubidx = upd_pc[IDX_BITS:1] when upd_taken=1 or upd_uncond=1:
    - valid=1, tag=upd_pc[15:IDX_BITS+1], target=upd_target, uc=upd_uncond
    - an aliasing entry with a different tag is overwritten
  - Not-taken conditional branches never allocate and never invalidate.
  - PHT, conditional branches only (upd_uncond=0):
    - cnt[upd_pht_idx] increments on taken, decrements on not-taken
    - saturates at 2'b11 and 2'b00
  - GHR, conditional branches only: ghr <= {ghr[IDX_BITS-2:0], upd_taken}.
  - Unconditional updates leave PHT and GHR unchanged.
- GHR is non-speculative: it is updated only at resolution. Flushed instructions never update because they carry no upd_valid.
- Same-cycle lookup and update of the same entry: lookup returns the pre-update value; there is no bypass. The new value is visible the next cycle.
- upd_pht_idx is used verbatim and is never recomputed from upd_pc.

Decomposition:
- lc3b_types gains:
  - constant BP_IDX_BITS
  - struct btb_entry_t {valid, uc, tag, target}
  - typedef pht_cnt_t (logic [1:0])
- One sub-module, pht_array: counter array, saturating update, reset-to-01, combinational read port.
- BTB storage and GHR stay in branch_predictor.

Test Plan:
- Reset with upd_valid=1 held high -> for any if_pc: btb_hit=0, btb_uc=0, btb_target=0, pht_out=0; pht_idx=if_pc[4:1]; the update is ignored.
- Conditional update with upd_pc=0x0040, target 0x0060, taken, upd_pht_idx=0 -> next cycle, if_pc=0x0040 gives btb_hit=1, btb_uc=0, btb_target=0x0060; ghr=0001 so pht_idx=1 and pht_out=0 (cnt[1]=01); cnt[0]=10.
- Four taken updates at upd_pht_idx=5 -> cnt[5] goes 10, 11, 11, 11. Then two not-taken -> 10 (pht_out=1), then 01 (pht_out=0).
- Unconditional update with upd_pc=0x1000, target 0x2000 -> if_pc=0x1000 gives btb_hit=1, btb_uc=1, btb_target=0x2000; ghr and all counters unchanged.
- Alias: allocate 0x0040->0x0060, then taken update 0x0060->0x0100 (same bidx=0) -> if_pc=0x0040 gives btb_hit=0; if_pc=0x0060 gives btb_hit=1, btb_target=0x0100.
- if_pc=0x0040 while an upd_valid for 0x0040 is applied in the same cycle -> outputs show the old entry that cycle and the new entry the next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared LC-3b types used by the fetch-stage branch predictor.
// BTB entry layout, PHT counter type and the saturating counter step.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int BP_IDX_BITS = 4;
    localparam int BP_TAG_BITS = 15 - BP_IDX_BITS;

    typedef logic [1:0] pht_cnt_t;

    localparam pht_cnt_t PHT_INIT = 2'b01;

    typedef struct packed {
        logic                   valid;
        logic                   uc;
        logic [BP_TAG_BITS-1:0] tag;
        lc3b_word               target;
    } btb_entry_t;

    // Two-bit saturating step: up on taken, down on not-taken, clamp at 00/11.
    function automatic pht_cnt_t pht_next(input pht_cnt_t cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_pht_array.sv
// Pattern history table: 2-bit saturating counters with a combinational
// read port and one write port driven by branch resolution.
module pht_array
    import lc3b_types::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    pht_cnt_t cnt [ENTRIES];

    // NOTE: every counter is reset explicitly, which keeps the array in flops
    // rather than RAM; a RAM macro could not be cleared in a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt[i] <= PHT_INIT;
        end else if (upd_en) begin
            // NOTE: non-blocking, so a read of the same counter this cycle
            // still returns the pre-update value.
            cnt[upd_idx] <= pht_next(cnt[upd_idx], upd_taken);
        end
    end

    assign rd_taken = cnt[rd_idx][1];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus gshare PHT,
// looked up combinationally from if_pc and trained from MEM-stage resolution.
module branch_predictor
    import lc3b_types::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int TAG_BITS = 15 - IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         if_pc,
    output logic                btb_hit,
    output logic                btb_uc,
    output logic [15:0]         btb_target,
    output logic                pht_out,
    output logic [IDX_BITS-1:0] pht_idx,
    input  logic                upd_valid,
    input  logic [15:0]         upd_pc,
    input  logic [15:0]         upd_target,
    input  logic                upd_taken,
    input  logic                upd_uncond,
    input  logic [IDX_BITS-1:0] upd_pht_idx
);

    localparam int ENTRIES = 1 << IDX_BITS;

    btb_entry_t          btb [ENTRIES];
    btb_entry_t          rd_entry;
    btb_entry_t          wr_entry;
    logic [IDX_BITS-1:0] ghr;
    logic [IDX_BITS-1:0] bidx;
    logic [IDX_BITS-1:0] ubidx;
    logic [TAG_BITS-1:0] tag;
    logic                alloc;
    logic                cond_upd;

    // Lookup
    assign bidx     = if_pc[IDX_BITS:1];
    assign tag      = if_pc[15:IDX_BITS+1];
    assign pht_idx  = bidx ^ ghr;
    assign rd_entry = btb[bidx];

    assign btb_hit    = rd_entry.valid && (rd_entry.tag == tag);
    assign btb_uc     = btb_hit && rd_entry.uc;
    assign btb_target = rd_entry.target;

    // Training: only taken or unconditional branches allocate; conditionals
    // alone train the PHT and shift the (non-speculative) history.
    assign ubidx    = upd_pc[IDX_BITS:1];
    assign alloc    = upd_valid && (upd_taken || upd_uncond);
    assign cond_upd = upd_valid && !upd_uncond;
    assign wr_entry = '{valid: 1'b1, uc: upd_uncond, tag: upd_pc[15:IDX_BITS+1], target: upd_target};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '0;
            ghr <= '0;
        end else begin
            if (alloc)
                btb[ubidx] <= wr_entry;
            if (cond_upd)
                ghr <= {ghr[IDX_BITS-2:0], upd_taken};
        end
    end

    pht_array #(
        .IDX_BITS (IDX_BITS)
    ) u_pht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pht_idx),
        .rd_taken  (pht_out),
        .upd_en    (cond_upd),
        .upd_idx   (upd_pht_idx),
        .upd_taken (upd_taken)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, PHT saturation,
// unconditional updates, aliasing and same-cycle lookup/update ordering.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_pc;
    logic        btb_hit;
    logic        btb_uc;
    logic [15:0] btb_target;
    logic        pht_out;
    logic [3:0]  pht_idx;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_uncond;
    logic [3:0]  upd_pht_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ghr_m = 4'h0;  // bench copy of the global history

    branch_predictor dut (
        .clk         (clk),
        .reset       (reset),
        .if_pc       (if_pc),
        .btb_hit     (btb_hit),
        .btb_uc      (btb_uc),
        .btb_target  (btb_target),
        .pht_out     (pht_out),
        .pht_idx     (pht_idx),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_uncond  (upd_uncond),
        .upd_pht_idx (upd_pht_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input logic [15:0] pc);
        if_pc = pc;
        #1;
    endtask

    // Drive one resolution pulse; it is consumed by the next rising edge.
    task automatic drive_upd(input logic [15:0] pc, input logic [15:0] tgt,
                             input logic taken, input logic uncond, input logic [3:0] idx);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_target  = tgt;
        upd_taken   = taken;
        upd_uncond  = uncond;
        upd_pht_idx = idx;
    endtask

    task automatic finish_upd();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        if (!upd_uncond)
            ghr_m = {ghr_m[2:0], upd_taken};
    endtask

    task automatic update(input logic [15:0] pc, input logic [15:0] tgt,
                          input logic taken, input logic uncond, input logic [3:0] idx);
        drive_upd(pc, tgt, taken, uncond, idx);
        finish_upd();
    endtask

    // Read cnt[k] through the lookup port by choosing bidx = k ^ ghr.
    task automatic check_cnt(input string tag, input logic [3:0] k, input logic exp_msb);
        logic [3:0] b;
        b = k ^ ghr_m;
        look({11'd0, b, 1'b0});
        check({tag, "_idx"}, 16'(pht_idx), 16'(k));
        check({tag, "_pht"}, 16'(pht_out), 16'(exp_msb));
    endtask

    logic exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset     = 1'b1;
        if_pc     = 16'h0040;
        upd_valid = 1'b0;
        upd_pc    = '0; upd_target = '0; upd_taken = 1'b0;
        upd_uncond = 1'b0; upd_pht_idx = '0;

        // Reset wins over a simultaneous update
        drive_upd(16'h0040, 16'h0060, 1'b1, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        upd_valid = 1'b0;
        look(16'h0040);
        check("rst_hit",    16'(btb_hit), 16'd0);
        check("rst_uc",     16'(btb_uc),  16'd0);
        check("rst_target", btb_target,   16'h0000);
        check("rst_pht",    16'(pht_out), 16'd0);
        check("rst_idx",    16'(pht_idx), 16'd0);
        look(16'h001E);
        check("rst_idx_f",  16'(pht_idx), 16'hF);
        check("rst_pht_f",  16'(pht_out), 16'd0);

        // Conditional taken allocation
        update(16'h0040, 16'h0060, 1'b1, 1'b0, 4'd0);
        look(16'h0040);
        check("c_hit",    16'(btb_hit), 16'd1);
        check("c_uc",     16'(btb_uc),  16'd0);
        check("c_target", btb_target,   16'h0060);
        check("c_idx",    16'(pht_idx), 16'd1);
        check("c_pht",    16'(pht_out), 16'd0);
        check_cnt("c_cnt0", 4'd0, 1'b1);
        look(16'h0002);
        check("c_miss1",  16'(btb_hit), 16'd0);

        // PHT saturation at index 5: four taken, then two not-taken
        for (int i = 0; i < 6; i++) begin
            update(16'h0100, 16'h0000, (i < 4) ? 1'b1 : 1'b0, 1'b0, 4'd5);
            check_cnt($sformatf("sat%0d", i), 4'd5, exp_seq[i]);
        end
        check("ghr_after_sat", 16'(ghr_m), 16'hC);

        // Unconditional: allocates with uc, leaves history and counters alone
        update(16'h1000, 16'h2000, 1'b1, 1'b1, 4'd5);
        look(16'h1000);
        check("u_hit",    16'(btb_hit), 16'd1);
        check("u_uc",     16'(btb_uc),  16'd1);
        check("u_target", btb_target,   16'h2000);
        check("u_idx",    16'(pht_idx), 16'hC);
        check_cnt("u_cnt5", 4'd5, 1'b0);
        check_cnt("u_cnt0", 4'd0, 1'b1);
        look(16'h0040);
        check("u_evict",  16'(btb_hit), 16'd0);

        // Aliasing at bidx 0
        update(16'h0040, 16'h0060, 1'b1, 1'b0, 4'd3);
        look(16'h0040);
        check("a_hit40",  16'(btb_hit), 16'd1);
        update(16'h0060, 16'h0100, 1'b1, 1'b0, 4'd3);
        look(16'h0040);
        check("a_miss40", 16'(btb_hit), 16'd0);
        look(16'h0060);
        check("a_hit60",  16'(btb_hit), 16'd1);
        check("a_uc60",   16'(btb_uc),  16'd0);
        check("a_tgt60",  btb_target,   16'h0100);
        check_cnt("a_cnt3", 4'd3, 1'b1);

        // Not-taken conditionals neither allocate nor invalidate
        update(16'h0060, 16'h0200, 1'b0, 1'b0, 4'd7);
        update(16'h0004, 16'h0300, 1'b0, 1'b0, 4'd7);
        look(16'h0060);
        check("nt_hit60", 16'(btb_hit), 16'd1);
        check("nt_tgt60", btb_target,   16'h0100);
        look(16'h0004);
        check("nt_miss4", 16'(btb_hit), 16'd0);
        check_cnt("nt_cnt7", 4'd7, 1'b0);

        // Same-cycle lookup and update: old entry now, new entry next cycle
        look(16'h0040);
        drive_upd(16'h0040, 16'h0080, 1'b1, 1'b0, 4'd7);
        #1;
        check("sc_old_hit", 16'(btb_hit), 16'd0);
        check("sc_old_tgt", btb_target,   16'h0100);
        check("sc_old_idx", 16'(pht_idx), 16'hC);
        finish_upd();
        check("sc_new_hit", 16'(btb_hit), 16'd1);
        check("sc_new_tgt", btb_target,   16'h0080);
        check("sc_new_idx", 16'(pht_idx), 16'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
